// File: rtl/dbg_probe_capture.sv
// Debug-overlay probe feeder: samples the Z80 bus, captures on a masked address trigger
// and publishes eight probe rows on vsync. Optional halt/step support via DBG_PROBE_BREAK_EN.
module dbg_probe_capture #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int HIT_W  = 8
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              bus_valid,
    input  logic [ADDR_W-1:0] z80_addr,
    input  logic [DATA_W-1:0] z80_data,
    input  logic [7:0]        boot_data,
    input  logic [15:0]       bram_data,
    input  logic              vsync,
    input  logic              freeze,
    input  logic              trig_en,
    input  logic              trig_oneshot,
    input  logic              trig_rearm,
    input  logic [ADDR_W-1:0] trig_addr,
    input  logic [ADDR_W-1:0] trig_mask,
    input  logic              step,
    output logic [15:0]       probe0,
    output logic [15:0]       probe1,
    output logic [15:0]       probe2,
    output logic [15:0]       probe3,
    output logic [15:0]       probe4,
    output logic [15:0]       probe5,
    output logic [15:0]       probe6,
    output logic [15:0]       probe7
`ifdef DBG_PROBE_BREAK_EN
    ,
    output logic              halt_req
`endif
);

    typedef enum logic [1:0] {IDLE, ARMED, HELD} trig_state_t;

    trig_state_t state, state_next;

    logic              vsync_q;
    logic [15:0]       live_addr, live_data, cap_addr, cap_data;
    logic [7:0]        boot_q;
    logic [15:0]       bram_q;
    logic [HIT_W-1:0]  hit_cnt;
    logic [15:0]       cyc_cnt, frame_cnt;
    logic              vs_edge, hit, capture, step_act;

    assign vs_edge = vsync & ~vsync_q;
    assign hit     = bus_valid & trig_en & (((z80_addr ^ trig_addr) & trig_mask) == '0);

`ifdef DBG_PROBE_BREAK_EN
    assign step_act = step;
`else
    logic unused_step;
    assign unused_step = step;
    assign step_act    = 1'b0;
`endif

    // A step in the same cycle as a hit suppresses the capture entirely
    assign capture = (state == ARMED) & hit & ~step_act;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = ARMED;
            ARMED:   if (capture && trig_oneshot) state_next = HELD;
            HELD:    if (trig_rearm) state_next = ARMED;
            default: state_next = IDLE;
        endcase
        if (step_act) state_next = ARMED;
        if (!trig_en) state_next = IDLE;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            vsync_q   <= 1'b0;
            live_addr <= '0;
            live_data <= '0;
            boot_q    <= '0;
            bram_q    <= '0;
            cap_addr  <= '0;
            cap_data  <= '0;
            hit_cnt   <= '0;
            cyc_cnt   <= '0;
            frame_cnt <= '0;
        end else begin
            vsync_q <= vsync;
            boot_q  <= boot_data;
            bram_q  <= bram_data;
            if (bus_valid) begin
                live_addr <= 16'(z80_addr);
                live_data <= 16'(z80_data);
            end
            if (capture) begin
                cap_addr <= 16'(z80_addr);
                cap_data <= 16'(z80_data);
                if (hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
            end
            // The edge cycle's own strobe opens the new frame's count
            if (vs_edge) begin
                cyc_cnt   <= bus_valid ? 16'd1 : 16'd0;
                frame_cnt <= frame_cnt + 16'd1;
            end else if (bus_valid && cyc_cnt != 16'hFFFF) begin
                cyc_cnt <= cyc_cnt + 16'd1;
            end
        end
    end

    // Registers still hold pre-edge values here, so the snapshot is never torn
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            probe0 <= '0;
            probe1 <= '0;
            probe2 <= '0;
            probe3 <= '0;
            probe4 <= '0;
            probe5 <= '0;
            probe6 <= '0;
            probe7 <= '0;
        end else if (vs_edge && !freeze) begin
            probe0 <= live_addr;
            probe1 <= live_data;
            probe2 <= {boot_q, 8'(hit_cnt)};
            probe3 <= bram_q;
            probe4 <= cap_addr;
            probe5 <= cap_data;
            probe6 <= frame_cnt;
            probe7 <= cyc_cnt;
        end
    end

`ifdef DBG_PROBE_BREAK_EN
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n)       halt_req <= 1'b0;
        else if (!trig_en)  halt_req <= 1'b0;
        else if (step_act)  halt_req <= 1'b0;
        else if (capture)   halt_req <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_dbg_probe_capture.sv
// Directed self-checking bench for dbg_probe_capture; break tests run when DBG_PROBE_BREAK_EN is defined.
module tb_dbg_probe_capture;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        bus_valid;
    logic [15:0] z80_addr, z80_data;
    logic [7:0]  boot_data;
    logic [15:0] bram_data;
    logic        vsync, freeze, trig_en, trig_oneshot, trig_rearm, step;
    logic [15:0] trig_addr, trig_mask;
    logic [15:0] probe0, probe1, probe2, probe3, probe4, probe5, probe6, probe7;
`ifdef DBG_PROBE_BREAK_EN
    logic        halt_req;
`endif

    int checkCount = 0;
    int failCount  = 0;

    dbg_probe_capture dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .bus_valid(bus_valid),
        .z80_addr(z80_addr), .z80_data(z80_data), .boot_data(boot_data),
        .bram_data(bram_data), .vsync(vsync), .freeze(freeze), .trig_en(trig_en),
        .trig_oneshot(trig_oneshot), .trig_rearm(trig_rearm), .trig_addr(trig_addr),
        .trig_mask(trig_mask), .step(step),
        .probe0(probe0), .probe1(probe1), .probe2(probe2), .probe3(probe3),
        .probe4(probe4), .probe5(probe5), .probe6(probe6), .probe7(probe7)
`ifdef DBG_PROBE_BREAK_EN
        , .halt_req(halt_req)
`endif
    );

    always #5 clk_sys = ~clk_sys;

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(negedge clk_sys);
    endtask

    // One bus strobe (or a plain idle cycle when valid is 0)
    task automatic applyStimulus(input logic valid, input logic [15:0] addr, input logic [15:0] data);
        bus_valid = valid;
        z80_addr  = addr;
        z80_data  = data;
        tick();
        bus_valid = 1'b0;
    endtask

    task automatic vsPulse();
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        tick();
    endtask

    initial begin
        reset_n = 1'b0; bus_valid = 0; z80_addr = 0; z80_data = 0; boot_data = 0; bram_data = 0;
        vsync = 0; freeze = 0; trig_en = 0; trig_oneshot = 0; trig_rearm = 0; step = 0;
        trig_addr = 0; trig_mask = 0;
        repeat (3) tick();
        checkOutput("reset_p0", probe0, 16'h0000);
        checkOutput("reset_p6", probe6, 16'h0000);
        checkOutput("reset_p7", probe7, 16'h0000);
        reset_n = 1'b1;
        tick();

        // Three idle frames
        repeat (3) vsPulse();
        checkOutput("idle_p0", probe0, 16'h0000);
        checkOutput("idle_p1", probe1, 16'h0000);
        checkOutput("idle_p2", probe2, 16'h0000);
        checkOutput("idle_p3", probe3, 16'h0000);
        checkOutput("idle_p4", probe4, 16'h0000);
        checkOutput("idle_p5", probe5, 16'h0000);
        checkOutput("idle_p6", probe6, 16'h0002);
        checkOutput("idle_p7", probe7, 16'h0000);

        // 100 strobes in one frame
        boot_data = 8'hA5; bram_data = 16'h1234;
        vsPulse();
        for (int i = 0; i < 99; i++) applyStimulus(1'b1, 16'(i), 16'(i + 7));
        applyStimulus(1'b1, 16'h4000, 16'h00C3);
        vsPulse();
        checkOutput("cnt_p7", probe7, 16'h0064);
        checkOutput("cnt_p0", probe0, 16'h4000);
        checkOutput("cnt_p1", probe1, 16'h00C3);
        checkOutput("cnt_p2", probe2, 16'hA500);
        checkOutput("cnt_p3", probe3, 16'h1234);
        checkOutput("cnt_p6", probe6, 16'h0004);

        // One-shot trigger, then rearm
        trig_addr = 16'h8000; trig_mask = 16'hF000; trig_oneshot = 1'b1; trig_en = 1'b1;
        tick();
        applyStimulus(1'b1, 16'h8123, 16'h0011);
        applyStimulus(1'b1, 16'h8456, 16'h0022);
        vsPulse();
        checkOutput("os_p4", probe4, 16'h8123);
        checkOutput("os_p5", probe5, 16'h0011);
        checkOutput("os_p2", probe2, 16'hA501);
        checkOutput("os_p7", probe7, 16'h0002);
        trig_rearm = 1'b1; tick(); trig_rearm = 1'b0;
        applyStimulus(1'b1, 16'h7FFF, 16'h0099);
        applyStimulus(1'b1, 16'h8456, 16'h0033);
        vsPulse();
        checkOutput("rearm_p4", probe4, 16'h8456);
        checkOutput("rearm_p5", probe5, 16'h0033);
        checkOutput("rearm_p2", probe2, 16'hA502);

        // Freeze across two frames
        freeze = 1'b1;
        applyStimulus(1'b1, 16'h1111, 16'h0040);
        vsPulse();
        applyStimulus(1'b1, 16'h2222, 16'h0044);
        vsPulse();
        checkOutput("frz_p0", probe0, 16'h8456);
        checkOutput("frz_p1", probe1, 16'h0033);
        freeze = 1'b0;
        vsPulse();
        checkOutput("unfrz_p0", probe0, 16'h2222);
        checkOutput("unfrz_p1", probe1, 16'h0044);
        checkOutput("unfrz_p6", probe6, 16'h0009);

        // Hit coincident with vsync edge in recapture mode
        trig_oneshot = 1'b0;
        trig_rearm = 1'b1; tick(); trig_rearm = 1'b0;
        applyStimulus(1'b1, 16'h8000, 16'h0055);
        vsync = 1'b1; bus_valid = 1'b1; z80_addr = 16'h8001; z80_data = 16'h0066;
        tick();
        vsync = 1'b0; bus_valid = 1'b0;
        tick();
        checkOutput("coin_p4", probe4, 16'h8000);
        checkOutput("coin_p2", probe2, 16'hA503);
        checkOutput("coin_p7", probe7, 16'h0001);
        vsPulse();
        checkOutput("coin2_p4", probe4, 16'h8001);
        checkOutput("coin2_p5", probe5, 16'h0066);
        checkOutput("coin2_p2", probe2, 16'hA504);
        checkOutput("coin2_p7", probe7, 16'h0001);

        // Hit counter saturation
        for (int i = 0; i < 260; i++) applyStimulus(1'b1, 16'h8000 + 16'(i), 16'(i));
        vsPulse();
        checkOutput("sat_p2", probe2, 16'hA5FF);
        checkOutput("sat_p7", probe7, 16'h0104);
        checkOutput("sat_p4", probe4, 16'h8103);

        // Disabled trigger retains captures
        trig_en = 1'b0;
        applyStimulus(1'b1, 16'h8F00, 16'h0077);
        vsPulse();
        checkOutput("dis_p4", probe4, 16'h8103);
        checkOutput("dis_p0", probe0, 16'h8F00);

        // Asynchronous reset mid-frame
        applyStimulus(1'b1, 16'h1234, 16'h0001);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("areset_p0", probe0, 16'h0000);
        checkOutput("areset_p6", probe6, 16'h0000);
        tick();
        reset_n = 1'b1;
        tick();
        vsPulse();
        checkOutput("postrst_p6", probe6, 16'h0000);
        checkOutput("postrst_p2", probe2, 16'hA500);

`ifdef DBG_PROBE_BREAK_EN
        trig_oneshot = 1'b1; trig_en = 1'b1;
        tick();
        applyStimulus(1'b1, 16'h8000, 16'h0001);
        checkOutput("brk_halt", {15'd0, halt_req}, 16'h0001);
        step = 1'b1; tick(); step = 1'b0;
        checkOutput("brk_step", {15'd0, halt_req}, 16'h0000);
        applyStimulus(1'b1, 16'h8001, 16'h0002);
        checkOutput("brk_armed", {15'd0, halt_req}, 16'h0001);
        step = 1'b1;
        applyStimulus(1'b1, 16'h8002, 16'h0003);
        step = 1'b0;
        checkOutput("brk_stephit", {15'd0, halt_req}, 16'h0000);
        vsPulse();
        checkOutput("brk_p2", probe2, 16'hA502);
        checkOutput("brk_p4", probe4, 16'h8001);
        trig_en = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/dbg_probe_capture.md
Name: dbg_probe_capture

Overview:
- Upstream feeder for the on-screen debug overlay. Drives its eight 16-bit hex probe rows.
- Samples the Z80 bus and memory data paths every valid bus cycle and captures a snapshot on a masked address trigger.
- Counts frames and bus cycles per frame.
- Publishes all eight probe words only on a vsync rising edge, so the overlay never shows a torn, mid-frame update.

Parameters:
- ADDR_W, 16, Z80 address width; zero-extended to 16 on probes.
- DATA_W, 16, bus data width; must be ≤16; zero-extended.
- HIT_W, 8, width of the saturating trigger-hit counter.

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- bus_valid  in  1  one-cycle strobe: addr/data valid this cycle.
- z80_addr  in  ADDR_W  CPU address.
- z80_data  in  DATA_W  CPU data.
- boot_data  in  8  boot ROM byte.
- bram_data  in  16  BRAM read word.
- vsync  in  1  active-high vertical sync, same clock domain.
- freeze  in  1  1 = hold published probes.
- trig_en  in  1  trigger enable.
- trig_oneshot  in  1  0 = recapture every hit, 1 = capture first hit then hold.
- trig_rearm  in  1  one-cycle pulse: HELD -> ARMED.
- trig_addr  in  ADDR_W  match address.
- trig_mask  in  ADDR_W  1 = bit compared.
- step  in  1  one-cycle step pulse. Used only with the optional feature.
- probe0..probe7  out  16 each  overlay rows.
- halt_req  out  1  CPU halt request. Present only with the optional feature.

Behaviour:
- Reset: all internal registers, probe0..7 and halt_req = 0; trigger FSM = IDLE.
- Live shadow registers, updated on a cycle with bus_valid=1:
  - live_addr <= z80_addr, live_data <= z80_data.
  - boot_data and bram_data are sampled every cycle.
- hit = bus_valid & trig_en & (((z80_addr ^ trig_addr) & trig_mask) == 0).
- Trigger FSM:
  - IDLE: go to ARMED when trig_en=1.
  - ARMED: on hit, cap_addr/cap_data <= bus values and hit_cnt += 1 (saturates at all-ones). If trig_oneshot=1 go to HELD, else stay ARMED.
  - HELD: ignore hits; trig_rearm -> ARMED.
  - From any state, trig_en=0 -> IDLE; cap registers and hit_cnt are retained.
  - trig_rearm while ARMED or IDLE: no effect.
- Per-frame counters:
  - vs_edge = vsync & ~vsync_q; vsync_q is a registered copy of vsync.
  - cyc_cnt increments on bus_valid and saturates at 0xFFFF.
  - On vs_edge: cyc_pub <= cyc_cnt; cyc_cnt <= bus_valid ? 1 : 0; frame_cnt += 1 (16-bit, wraps 0xFFFF -> 0).
- Publish on vs_edge & ~freeze, one-cycle latency from the edge. Values are the shadow values as of the cycle before the edge (so the cycle's own bus_valid is excluded):
  - probe0 = live_addr
  - probe1 = live_data
  - probe2 = {boot_data, hit_cnt (zero-padded or truncated to 8)}
  - probe3 = bram_data
  - probe4 = cap_addr
  - probe5 = cap_data
  - probe6 = frame_cnt (pre-increment)
  - probe7 = cyc_pub value being stored
- freeze=1: probes hold; counters keep running. On the first vs_edge after freeze drops, current values are published.
- Hit and vs_edge in the same cycle: the capture lands in the cap registers, and the publish shows the pre-hit values.
- Reset asserted mid-frame: everything clears immediately (async). After release, the first publish happens on the next vs_edge.

Optional Feature:
- Macro: DBG_PROBE_BREAK_EN.
- Defined: halt_req is set the cycle after any captured hit, in either mode.
  - A step pulse clears halt_req the next cycle and forces the FSM to ARMED.
  - A step and a hit in the same cycle: step wins; the hit is ignored, not captured and not counted.
  - trig_en=0 clears halt_req.
- Undefined: no halt_req port; step is ignored; no extra logic.

Test Plan:
- Reset release, 3 vsync pulses, no bus activity -> probes 0..5 = 0x0000, probe6 = 0x0002, probe7 = 0x0000.
- 100 bus_valid strobes between two vsync edges, last addr 0x4000 / data 0x00C3 -> after second edge: probe7 = 0x0064, probe0 = 0x4000, probe1 = 0x00C3.
- trig_addr = 0x8000, mask = 0xF000, oneshot = 1; bus hits 0x8123 then 0x8456 -> probe4 = 0x8123, probe2[7:0] = 0x01. After trig_rearm and a hit at 0x8456 -> probe4 = 0x8456, hit_cnt = 0x02.
- freeze=1 across 2 frames with changing addresses -> probes unchanged. freeze=0 -> next vs_edge publishes the latest values.
- Hit coincident with vs_edge (addr 0x8001, previous cap 0x8000) -> that publish shows 0x8000; the next frame shows 0x8001.
- DBG_PROBE_BREAK_EN: hit at 0x8000 -> halt_req=1 next cycle. step pulse -> halt_req=0 next cycle, FSM ARMED. step plus hit in the same cycle -> hit_cnt unchanged.
